// File: rtl/multicycle_cu_pkg.sv
// Shared types and constants for the multicycle control unit.
// MULTICYCLE_CU_BRANCH_EN adds BEQ to the set of legal opcodes.
package multicycle_cu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam int unsigned OP_R    = 0;
  localparam int unsigned OP_ADDI = 1;
  localparam int unsigned OP_LW   = 2;
  localparam int unsigned OP_SW   = 3;
  localparam int unsigned OP_BEQ  = 4;

  localparam int unsigned ALU_ADD   = 0;
  localparam int unsigned ALU_FUNCT = 1;
  localparam int unsigned ALU_SUB   = 2;

  function automatic logic isLegal(input int unsigned op);
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW: isLegal = 1'b1;
`ifdef MULTICYCLE_CU_BRANCH_EN
      OP_BEQ:                      isLegal = 1'b1;
`endif
      default:                     isLegal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_cu_decode.sv
// Combinational strobe decode from FSM state and opcode.
// MULTICYCLE_CU_BRANCH_EN enables the BEQ execute decode.
module cu_decode
  import multicycle_cu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 2
) (
  input  logic                active,
  input  state_t              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [OPCODE_W-1:0] opLatched,
  input  logic                memReady,
  input  logic                zero,
  output logic                pcWrite,
  output logic                irWrite,
  output logic                regDst,
  output logic                aluSrc,
  output logic                memToReg,
  output logic                regWrite,
  output logic                memRead,
  output logic                memWrite,
  output logic                pcSrc,
  output logic [ALUOP_W-1:0]  aluOp,
  output logic                illegal
);

  int unsigned opLive;
  int unsigned opL;

  assign opLive = 32'(opcode);
  assign opL    = 32'(opLatched);

`ifndef MULTICYCLE_CU_BRANCH_EN
  logic unusedZero;
  assign unusedZero = zero;
`endif

  always_comb begin
    pcWrite  = 1'b0;
    irWrite  = 1'b0;
    regDst   = 1'b0;
    aluSrc   = 1'b0;
    memToReg = 1'b0;
    regWrite = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    pcSrc    = 1'b0;
    aluOp    = ALUOP_W'(ALU_ADD);
    illegal  = 1'b0;
    // Everything stays low while reset is held, regardless of stale state.
    if (active) begin
      case (state)
        FETCH: begin
          memRead = 1'b1;
          irWrite = memReady;
          pcWrite = memReady;
        end
        // The opcode is only latched at the end of DECODE, so use the live value.
        DECODE: illegal = !isLegal(opLive);
        EXEC: begin
          case (opL)
            OP_R: begin
              aluOp  = ALUOP_W'(ALU_FUNCT);
              regDst = 1'b1;
            end
            OP_ADDI, OP_LW, OP_SW: aluSrc = 1'b1;
`ifdef MULTICYCLE_CU_BRANCH_EN
            OP_BEQ: begin
              aluOp   = ALUOP_W'(ALU_SUB);
              pcSrc   = zero;
              pcWrite = zero;
            end
`endif
            default: ;
          endcase
        end
        MEM: begin
          if (opL == OP_LW)      memRead  = 1'b1;
          else if (opL == OP_SW) memWrite = 1'b1;
        end
        WB: begin
          regWrite = 1'b1;
          regDst   = (opL == OP_R);
          memToReg = (opL == OP_LW);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle CPU control unit: state register plus cu_decode strobe decode.
// MULTICYCLE_CU_BRANCH_EN enables BEQ (opcode 4); otherwise it is illegal.
module multicycle_cu
  import multicycle_cu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                pc_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                illegal,
  output logic [2:0]          state_o
);

  state_t              state;
  logic [OPCODE_W-1:0] opLatched;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      opLatched <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) state <= DECODE;
        DECODE: begin
          opLatched <= opcode;
          state     <= isLegal(32'(opcode)) ? EXEC : FETCH;
        end
        EXEC: begin
          case (32'(opLatched))
            OP_R, OP_ADDI: state <= WB;
            OP_LW, OP_SW:  state <= MEM;
            default:       state <= FETCH;
          endcase
        end
        MEM: if (mem_ready) state <= (32'(opLatched) == OP_LW) ? WB : FETCH;
        WB:      state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  assign state_o = reset ? 3'd0 : state;

  cu_decode #(
    .OPCODE_W(OPCODE_W),
    .ALUOP_W (ALUOP_W)
  ) uDecode (
    .active   (!reset),
    .state    (state),
    .opcode   (opcode),
    .opLatched(opLatched),
    .memReady (mem_ready),
    .zero     (zero),
    .pcWrite  (pc_write),
    .irWrite  (ir_write),
    .regDst   (reg_dst),
    .aluSrc   (alu_src),
    .memToReg (mem_to_reg),
    .regWrite (reg_write),
    .memRead  (mem_read),
    .memWrite (mem_write),
    .pcSrc    (pc_src),
    .aluOp    (alu_op),
    .illegal  (illegal)
  );

endmodule
